uart_rx_fsm: RTL

Serial receiver stage that consumes the UART line produced by the transmitter FSM. It samples 8N1 frames (start bit, 8 data bits LSB first, 1 stop bit) at mid-bit using a parameterised bit period. It presents each received byte in a holding register with a valid/acknowledge handshake toward the consumer, and flags framing and overrun errors.

---
 rtl/uart_rx_fsm.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm
//
// 8N1 UART receiver. The serial line is synchronised, the start bit is
// qualified at mid-bit, and data and stop bits are sampled at their centres
// (CLKS_PER_BIT clocks per bit). A received byte is held in rx_data with a
// level valid and a consumer acknowledge. Bad stop bits and bytes lost to an
// unacknowledged holding register are flagged.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous reset, active low
//   rx            serial input, idle high, asynchronous to clk
//   rd_ack        consumer acknowledge; clears rx_valid and rx_overrun
//   rx_data[7:0]  last accepted byte, stable while rx_valid is high
//   rx_valid      byte available
//   rx_frame_err  one-cycle pulse when a stop bit is sampled low
//   rx_overrun    sticky: a good byte was dropped while rx_valid was high
//   rx_busy       receiver is inside a frame (state other than IDLE)
module uart_rx_fsm #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  sh, sh_n;
  logic [7:0]  data_n;
  logic        valid_n;
  logic        ferr_n;
  logic        ovr_n;
  logic        rx_m, rx_s;

  // Two-flop synchroniser; both flops reset to the idle line level so a
  // reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 16'd0;
      idx          <= 3'd0;
      sh           <= 8'h00;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      sh           <= sh_n;
      rx_data      <= data_n;
      rx_valid     <= valid_n;
      rx_frame_err <= ferr_n;
      rx_overrun   <= ovr_n;
      rx_busy      <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    idx_n   = idx;
    sh_n    = sh;
    data_n  = rx_data;
    valid_n = rx_valid;
    ferr_n  = 1'b0;
    ovr_n   = rx_overrun;

    // Acknowledge only matters while a byte is held; rx_overrun can only be
    // set while rx_valid is high, so both clear together.
    if (rd_ack && rx_valid) begin
      valid_n = 1'b0;
      ovr_n   = 1'b0;
    end

    case (state)
      IDLE: begin
        cnt_n = 16'd0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = 16'd0;
          idx_n   = 3'd0;
          // A line that is high again at mid start bit was a glitch.
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n = 16'd0;
          sh_n  = {rx_s, sh[7:1]};
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end
      end
      STOP: begin
        // Leave at mid stop bit so a start bit that follows immediately
        // is still seen from its falling edge.
        if (cnt == BIT_LAST) begin
          cnt_n   = 16'd0;
          state_n = IDLE;
          if (rx_s) begin
            // An acknowledge in this same cycle frees the holding register,
            // so the new byte loads instead of counting as an overrun.
            if (!rx_valid || rd_ack) begin
              data_n  = sh;
              valid_n = 1'b1;
            end else begin
              ovr_n = 1'b1;
            end
          end else begin
            ferr_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
